// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO controller.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MEM_DEPTH  = 8;
  localparam int DEF_PTR_WIDTH  = clog2(DEF_MEM_DEPTH) + 1;
  localparam int DEF_AE_THRESH  = 2;
  localparam int DEF_FWFT       = 0;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO: wrap-bit pointers, occupancy/status flags, sticky error flags,
// and either a registered or a first-word-fall-through read port.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int PTR_WIDTH  = clog2(MEM_DEPTH) + 1,
  parameter int AF_THRESH  = MEM_DEPTH - 2,
  parameter int AE_THRESH  = DEF_AE_THRESH,
  parameter int FWFT       = DEF_FWFT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLR,
  input  logic                  W_INC,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  R_INC,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [PTR_WIDTH-1:0]  Level,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int AW = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] AF_LVL = PTR_WIDTH'(AF_THRESH);
  localparam logic [PTR_WIDTH-1:0] AE_LVL = PTR_WIDTH'(AE_THRESH);

  logic [PTR_WIDTH-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign Level        = wptr_q - rptr_q;
  assign Empty        = (wptr_q == rptr_q);
  assign Full         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign Almost_Full  = (Level >= AF_LVL);
  assign Almost_Empty = (Level <= AE_LVL);
  assign Overflow     = ovf_q;
  assign Underflow    = udf_q;

  // Full/Empty are the pre-edge values, so a read at Full and a write at Empty still go through.
  assign wr_acc = W_INC & ~Full  & ~CLR;
  assign rd_acc = R_INC & ~Empty & ~CLR;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    if (CLR) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_WIDTH'(1);
      if (rd_acc) rptr_d = rptr_q + PTR_WIDTH'(1);
      if (W_INC && Full)  ovf_d = 1'b1;
      if (R_INC && Empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  sync_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (W_INC & ~Full),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (WR_DATA),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign RD_DATA = mem_rdata;
    end else begin : g_reg_rd
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_acc) rd_data_d = mem_rdata;
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rd_data_q <= '0;
        else      rd_data_q <= rd_data_d;
      end

      assign RD_DATA = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: table-driven fill/drain, hand-written corner sequences
// and random traffic against a queue-based model; a FWFT instance shares the stimulus.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       CLR = 1'b0;
  logic       W_INC = 1'b0;
  logic       R_INC = 1'b0;
  logic [7:0] WR_DATA = 8'h00;

  logic [7:0] RD_DATA, RD_DATA_F;
  logic       Full, Empty, AFull, AEmpty, Ovf, Udf;
  logic       Full_f, Empty_f, AFull_f, AEmpty_f, Ovf_f, Udf_f;
  logic [3:0] Level, Level_f;

  always #5 CLK = ~CLK;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .PTR_WIDTH(4),
    .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)
  ) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .R_INC(R_INC), .RD_DATA(RD_DATA), .Full(Full), .Empty(Empty),
    .Almost_Full(AFull), .Almost_Empty(AEmpty), .Level(Level),
    .Overflow(Ovf), .Underflow(Udf)
  );

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .MEM_DEPTH(DEPTH), .PTR_WIDTH(4),
    .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)
  ) dut_f (
    .CLK(CLK), .RST(RST), .CLR(CLR), .W_INC(W_INC), .WR_DATA(WR_DATA),
    .R_INC(R_INC), .RD_DATA(RD_DATA_F), .Full(Full_f), .Empty(Empty_f),
    .Almost_Full(AFull_f), .Almost_Empty(AEmpty_f), .Level(Level_f),
    .Overflow(Ovf_f), .Underflow(Udf_f)
  );

  // Reference model: contents as a queue, error flags, registered read value.
  logic [7:0] mq[$];
  bit         m_ovf, m_udf;
  logic [7:0] m_rd;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit         w;
    logic [7:0] wd;
    bit         r;
    int         lvl;
    bit         full, empty, af, ae, ovf, udf;
    logic [7:0] rd;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mv(bit w, logic [7:0] wd, bit r, int lvl, bit full, bit empty,
                              bit af, bit ae, bit ovf, bit udf, logic [7:0] rd);
    vec_t v;
    v.w = w; v.wd = wd; v.r = r; v.lvl = lvl; v.full = full; v.empty = empty;
    v.af = af; v.ae = ae; v.ovf = ovf; v.udf = udf; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_rd  = 8'h00;
  endtask

  task automatic model_step(input bit w, input logic [7:0] wd, input bit r, input bit c);
    bit was_full, was_empty;
    if (c) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) m_rd = mq.pop_front();
      if (w && !was_full) mq.push_back(wd);
    end
  endtask

  task automatic check_model(input string nm);
    int         n;
    logic [9:0] exp;
    n   = mq.size();
    exp = {n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_udf, 4'(n)};
    chk({nm, "_flags"}, 32'({Full, Empty, AFull, AEmpty, Ovf, Udf, Level}), 32'(exp));
    chk({nm, "_flags_fwft"},
        32'({Full_f, Empty_f, AFull_f, AEmpty_f, Ovf_f, Udf_f, Level_f}), 32'(exp));
    chk({nm, "_rd"}, 32'(RD_DATA), 32'(m_rd));
    if (n > 0) chk({nm, "_fwft_head"}, 32'(RD_DATA_F), 32'(mq[0]));
  endtask

  // Inputs are applied at the falling edge; outputs are sampled at the next falling edge.
  task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit c);
    W_INC = w; WR_DATA = wd; R_INC = r; CLR = c;
    @(posedge CLK);
    model_step(w, wd, r, c);
    @(negedge CLK);
    W_INC = 1'b0; R_INC = 1'b0; CLR = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // fill 0x01..0x08, overflow write, drain 8 words, underflow read
    vt[0]  = mv(1, 8'h01, 0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    vt[1]  = mv(1, 8'h02, 0, 2, 0, 0, 0, 1, 0, 0, 8'h00);
    vt[2]  = mv(1, 8'h03, 0, 3, 0, 0, 0, 0, 0, 0, 8'h00);
    vt[3]  = mv(1, 8'h04, 0, 4, 0, 0, 0, 0, 0, 0, 8'h00);
    vt[4]  = mv(1, 8'h05, 0, 5, 0, 0, 0, 0, 0, 0, 8'h00);
    vt[5]  = mv(1, 8'h06, 0, 6, 0, 0, 1, 0, 0, 0, 8'h00);
    vt[6]  = mv(1, 8'h07, 0, 7, 0, 0, 1, 0, 0, 0, 8'h00);
    vt[7]  = mv(1, 8'h08, 0, 8, 1, 0, 1, 0, 0, 0, 8'h00);
    vt[8]  = mv(1, 8'h09, 0, 8, 1, 0, 1, 0, 1, 0, 8'h00);
    vt[9]  = mv(0, 8'h00, 1, 7, 0, 0, 1, 0, 1, 0, 8'h01);
    vt[10] = mv(0, 8'h00, 1, 6, 0, 0, 1, 0, 1, 0, 8'h02);
    vt[11] = mv(0, 8'h00, 1, 5, 0, 0, 0, 0, 1, 0, 8'h03);
    vt[12] = mv(0, 8'h00, 1, 4, 0, 0, 0, 0, 1, 0, 8'h04);
    vt[13] = mv(0, 8'h00, 1, 3, 0, 0, 0, 0, 1, 0, 8'h05);
    vt[14] = mv(0, 8'h00, 1, 2, 0, 0, 0, 1, 1, 0, 8'h06);
    vt[15] = mv(0, 8'h00, 1, 1, 0, 0, 0, 1, 1, 0, 8'h07);
    vt[16] = mv(0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 0, 8'h08);
    vt[17] = mv(0, 8'h00, 1, 0, 0, 1, 0, 1, 1, 1, 8'h08);

    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_flags", 32'({Full, Empty, AFull, AEmpty, Ovf, Udf, Level}),
        32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}));
    chk("reset_rd", 32'(RD_DATA), 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check_model("post_reset");

    for (int i = 0; i < 18; i++) begin
      step(vt[i].w, vt[i].wd, vt[i].r, 1'b0);
      chk($sformatf("vec%0d_level", i), 32'(Level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d_flags", i), 32'({Full, Empty, AFull, AEmpty, Ovf, Udf}),
          32'({vt[i].full, vt[i].empty, vt[i].af, vt[i].ae, vt[i].ovf, vt[i].udf}));
      chk($sformatf("vec%0d_rd", i), 32'(RD_DATA), 32'(vt[i].rd));
      if (mq.size() > 0) chk($sformatf("vec%0d_fwft_head", i), 32'(RD_DATA_F), 32'(mq[0]));
    end

    // Boundary: write+read at Full, then write+read at Empty
    step(0, 8'h00, 0, 1);
    check_model("clr0");
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h10 + i), 0, 0);
    check_model("bnd_full");
    step(1, 8'hEE, 1, 0);
    chk("bnd_full_wr_rd_level", 32'(Level), 32'd7);
    chk("bnd_full_wr_rd_rd", 32'(RD_DATA), 32'h10);
    check_model("bnd_full_wr_rd");
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h00, 1, 0);
      check_model($sformatf("bnd_drain%0d", i));
    end
    step(1, 8'h3C, 1, 0);
    chk("bnd_empty_wr_rd_level", 32'(Level), 32'd1);
    chk("bnd_empty_wr_rd_udf", 32'(Udf), 32'd1);
    check_model("bnd_empty_wr_rd");
    step(0, 8'h00, 1, 0);
    chk("bnd_empty_readback", 32'(RD_DATA), 32'h3C);

    // Simultaneous access at Level=4 for 20 cycles (pointers wrap)
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h21 + i), 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 8'hAA, 1, 0);
      check_model($sformatf("simul%0d", i));
    end
    chk("simul_level", 32'(Level), 32'd4);

    // Flush at Level=5 with both error flags set; incs that cycle are ignored
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0);
    check_model("pre_clr");
    step(1, 8'h99, 1, 1);
    chk("clr_state", 32'({Level, Empty, Ovf, Udf}), 32'({4'd0, 1'b1, 1'b0, 1'b0}));
    check_model("post_clr");

    // Asynchronous reset mid-burst
    for (int i = 0; i < 3; i++) step(1, 8'(8'h50 + i), 0, 0);
    W_INC = 1'b1; WR_DATA = 8'h53; R_INC = 1'b1;
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_flags", 32'({Full, Empty, AFull, AEmpty, Ovf, Udf, Level}),
        32'({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0}));
    chk("rst_mid_rd", 32'(RD_DATA), 32'h0);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    W_INC = 1'b0; R_INC = 1'b0;
    RST = 1'b1;
    check_model("rst_release");
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("rst_first_word", 32'(RD_DATA), 32'h77);
    check_model("rst_after");

    // FWFT: head word appears without a read
    step(0, 8'h00, 0, 1);
    step(1, 8'h5A, 0, 0);
    chk("fwft_head", 32'(RD_DATA_F), 32'h5A);
    chk("fwft_empty", 32'(Empty_f), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
           $urandom_range(0, 49) == 0);
      check_model($sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
